lsmon: RTL

//  Passive low-speed serial line monitor/checker; the receiving counterpart of the lstx stimulus path.

---
 rtl/lsmon.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lsmon.sv
// lsmon: passive serial line monitor that decodes frames on a tapped line and checks each
// decoded word against a queue of expected words. Define LSMON_PARITY_EN to expect an even-parity bit.
module lsmon #(
  parameter int DMSB = 9,
  parameter int CMSB = 12,
  parameter int AMSB = 2,
  parameter int NMSB = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            setn,
  input  logic [CMSB:0]   div,
  input  logic            rx,
  input  logic            push,
  input  logic [DMSB:0]   wdata,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic [DMSB:0]   rdata,
  output logic            done,
  output logic            mism,
  output logic [NMSB:0]   nmatch,
  output logic [NMSB:0]   nerr
);

  localparam int DEPTH = 2 ** (AMSB + 1);
  localparam int BW    = $clog2(DMSB + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t          state;
  logic [CMSB:0]   cnt;
  logic [CMSB:0]   div_r;
  logic [BW-1:0]   bitn;
  logic [DMSB:0]   shreg;
  logic            par_err;
  logic            rx_m, rx_s, rx_d;
  logic            push_d, push_v;
  logic [AMSB+1:0] wp, rp;
  logic [DMSB:0]   mem [DEPTH];

  logic            at_end, at_half, fin, miss, pop, pedge, enq, drop;
  logic [NMSB+1:0] nerr_sum;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign empty   = (wp == rp);
  assign full    = (wp[AMSB+1] != rp[AMSB+1]) && (wp[AMSB:0] == rp[AMSB:0]);
  assign at_end  = (cnt == div_r);
  assign at_half = (cnt == (div_r >> 1));

  // Frame end: stop bit sampled; compare against the head as it stands this cycle.
  assign fin  = setn && (state == ST_STOP) && at_end;
  assign miss = !rx_s || par_err || empty || (mem[rp[AMSB:0]] != shreg);
  assign pop  = fin && !empty;

  // Push history is only trusted after its first post-reset load.
  assign pedge = push_v && (push ^ push_d);
  assign enq   = setn && pedge && !full;
  assign drop  = setn && pedge && full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_d <= 1'b0;
      push_v <= 1'b0;
    end else begin
      push_d <= push;
      push_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (!setn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; empty/full come from the pointers, so stale
  // entries are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (enq) mem[wp[AMSB:0]] <= wdata;
  end

  // A frame error and a dropped push in the same cycle both count.
  assign nerr_sum = {1'b0, nerr}
                  + {{(NMSB+1){1'b0}}, fin && miss}
                  + {{(NMSB+1){1'b0}}, drop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmatch <= '0;
      nerr   <= '0;
    end else begin
      if (fin && !miss && nmatch != '1) nmatch <= nmatch + 1'b1;
      nerr <= nerr_sum[NMSB+1] ? '1 : nerr_sum[NMSB:0];
    end
  end

  // NOTE: all state below is assigned with non-blocking assignments so every branch
  // reads the pre-edge values of cnt, shreg and the synchronizer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_r   <= {{CMSB{1'b0}}, 1'b1};
      bitn    <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      rdata   <= '0;
      done    <= 1'b0;
      mism    <= 1'b0;
    end else begin
      done <= 1'b0;
      mism <= 1'b0;
      if (!setn) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (rx_d && !rx_s) begin
              state <= ST_START;
              div_r <= (div == '0) ? {{CMSB{1'b0}}, 1'b1} : div;
            end
          end
          ST_START: begin
            if (at_half) begin
              cnt <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_DATA;
                bitn    <= '0;
                par_err <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (at_end) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DMSB:1]};
              bitn  <= bitn + 1'b1;
              if (bitn == BW'(DMSB)) begin
`ifdef LSMON_PARITY_EN
                state <= ST_PAR;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef LSMON_PARITY_EN
          ST_PAR: begin
            if (at_end) begin
              cnt     <= '0;
              par_err <= rx_s ^ (^shreg);
              state   <= ST_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (at_end) begin
              cnt   <= '0;
              state <= ST_IDLE;
              rdata <= shreg;
              done  <= 1'b1;
              mism  <= miss;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
